// File: rtl/frame_serializer_if.sv
// Handshake and data bus of the frame serializer: switch-bank inputs,
// transmit controls and the serial/status outputs.
interface frame_serializer_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 8
);
  logic              init;
  logic [DATA_W-1:0] sw;
  logic              start;
  logic              mode;
  logic              sel;
  logic              ser_out;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  out;

  modport master (
    output init, sw, start, mode, sel,
    input  ser_out, busy, done, out
  );

  modport slave (
    input  init, sw, start, mode, sel,
    output ser_out, busy, done, out
  );
endinterface

// File: rtl/frame_serializer.sv
// Serial message transmitter: captures a word on start and shifts it out
// MSB- or LSB-first with a programmable bit period and a status bus.
module frame_serializer #(
  parameter int DATA_W   = 10,
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 0,
  parameter int OUT_W    = 8
) (
  input logic               clk,
  input logic               rst,
  frame_serializer_if.slave bus
);
  localparam int RW = $clog2(DATA_W + 1);
  localparam int MW = (OUT_W > RW) ? OUT_W : RW;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic              order;
  logic [CNT_W-1:0]  div;
  logic [CNT_W-1:0]  pcnt;
  logic [RW-1:0]     rem;
  logic [OUT_W-1:0]  fcnt;
  logic [MW-1:0]     rem_w;

  logic load, shift, finish, div_load;
  logic ser_out, busy, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    div_load  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ser_out   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.init) begin
          div_load = 1'b1;
        end else if (bus.start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        busy    = 1'b1;
        ser_out = order ? shreg[0] : shreg[DATA_W-1];
        if (pcnt == '0) begin
          if (rem > RW'(1)) begin
            shift = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        // The edge ending DONE may already accept the next frame.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      order <= 1'b0;
      div   <= CNT_W'(DIV_INIT);
      pcnt  <= '0;
      rem   <= '0;
      fcnt  <= '0;
    end else begin
      if (div_load) div <= bus.sw[CNT_W-1:0];
      if (load) begin
        shreg <= bus.sw;
        order <= bus.mode;
        rem   <= RW'(DATA_W);
        pcnt  <= div;
      end else if (shift) begin
        shreg <= order ? (shreg >> 1) : (shreg << 1);
        rem   <= rem - 1'b1;
        pcnt  <= div;
      end else if (finish) begin
        rem  <= '0;
        fcnt <= fcnt + 1'b1;
      end else if (state == SEND) begin
        pcnt <= pcnt - 1'b1;
      end
    end
  end

  // Zero-extend or truncate bits-remaining to the status bus width.
  assign rem_w       = MW'(rem);
  assign bus.out     = bus.sel ? fcnt : rem_w[OUT_W-1:0];
  assign bus.ser_out = ser_out;
  assign bus.busy    = busy;
  assign bus.done    = done;
endmodule
